// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery-charger ADC sequencer: channel codes,
// FSM state encoding and the round-robin successor function.
package batcharger_pkg;

    localparam logic [1:0] CH_V = 2'b00;
    localparam logic [1:0] CH_I = 2'b01;
    localparam logic [1:0] CH_T = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_STORE   = 2'd3
    } state_t;

    // Fixed scan order V -> I -> T -> V; the unused code 11 falls back to V.
    function automatic logic [1:0] rr_next(input logic [1:0] ch);
        case (ch)
            CH_V:    rr_next = CH_I;
            CH_I:    rr_next = CH_T;
            default: rr_next = CH_V;
        endcase
    endfunction

endpackage

// File: rtl/batcharger_adcseq_if.sv
// Signal bundle between the ADC sequencer and the charger controller / ADC.
interface batcharger_adcseq_if;
    import batcharger_pkg::*;

    logic       en;
    logic       vmonen;
    logic       imonen;
    logic       tmonen;
    logic [1:0] adc_sel;
    logic       adc_start;
    logic       adc_eoc;
    logic [7:0] adc_data;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic       vtok;
    logic       err;
    state_t     state_dbg;

    // ADC handshake: adc_start is a one-cycle request with adc_sel stable; the
    // ADC answers with a one-cycle adc_eoc pulse carrying adc_data in that cycle.
    modport master (
        input  en, vmonen, imonen, tmonen, adc_eoc, adc_data,
        output adc_sel, adc_start, vbat, ibat, tbat, vtok, err, state_dbg
    );

    modport slave (
        output en, vmonen, imonen, tmonen, adc_eoc, adc_data,
        input  adc_sel, adc_start, vbat, ibat, tbat, vtok, err, state_dbg
    );

endinterface

// File: rtl/batcharger_rr_pick.sv
// Round-robin channel picker: first enabled channel strictly after last_ch.
module batcharger_rr_pick
    import batcharger_pkg::*;
(
    input  logic [1:0] last_ch,
    input  logic       vmonen,
    input  logic       imonen,
    input  logic       tmonen,
    output logic [1:0] next_ch,
    output logic       valid
);

    logic [1:0] cand;
    logic       hit;

    // Walking three steps visits every channel once and ends on last_ch itself,
    // so a lone enabled channel is picked again back-to-back.
    always_comb begin
        next_ch = CH_V;
        valid   = 1'b0;
        cand    = last_ch;
        hit     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = rr_next(cand);
            case (cand)
                CH_V:    hit = vmonen;
                CH_I:    hit = imonen;
                CH_T:    hit = tmonen;
                default: hit = 1'b0;
            endcase
            if (hit && !valid) begin
                next_ch = cand;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/batcharger_adcseq.sv
// ADC sequencer: round-robin conversion of battery voltage, current and
// temperature with settle delay, eoc timeout and per-channel valid flags.
module batcharger_adcseq
    import batcharger_pkg::*;
#(
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 63
) (
    input  logic                 clk,
    input  logic                 rstz,
    batcharger_adcseq_if.master  bus,
    inout  wire                  dvdd,
    inout  wire                  dgnd
);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] settle_cnt;
    logic [5:0] wait_cnt;
    logic [7:0] data_q;
    logic [1:0] sel_q;
    logic [1:0] last_ch;
    logic       start_q;
    logic [7:0] vbat_q;
    logic [7:0] ibat_q;
    logic [7:0] tbat_q;
    logic       vflag;
    logic       iflag;
    logic       tflag;
    logic       err_q;
    logic       vtok_q;

    logic [1:0] pick_ch;
    logic       pick_valid;
    logic       load_sel;
    logic       eoc_ok;
    logic       timeout;
    logic       store;

    // Supply pins carry no logic; folding them here keeps them referenced.
    wire unused_supply = dvdd ^ dgnd;

    batcharger_rr_pick u_pick (
        .last_ch (last_ch),
        .vmonen  (bus.vmonen),
        .imonen  (bus.imonen),
        .tmonen  (bus.tmonen),
        .next_ch (pick_ch),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_sel  = 1'b0;
        eoc_ok    = 1'b0;
        timeout   = 1'b0;
        store     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = ST_SETTLE;
                    load_sel  = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 8'(SETTLE - 1)) state_nxt = ST_CONVERT;
            end
            ST_CONVERT: begin
                // wait_cnt == 0 marks the start cycle, where eoc is ignored.
                if (wait_cnt != 6'd0 && bus.adc_eoc) begin
                    eoc_ok    = 1'b1;
                    state_nxt = ST_STORE;
                end else if (wait_cnt == 6'(TIMEOUT)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_STORE: begin
                store     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!bus.en) begin
            state_nxt = ST_IDLE;
            load_sel  = 1'b0;
            eoc_ok    = 1'b0;
            timeout   = 1'b0;
            store     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            settle_cnt <= 8'd0;
            wait_cnt   <= 6'd0;
            data_q     <= 8'h00;
            sel_q      <= CH_V;
            last_ch    <= CH_T;
            start_q    <= 1'b0;
            vbat_q     <= 8'h00;
            ibat_q     <= 8'h00;
            tbat_q     <= 8'h00;
            vflag      <= 1'b0;
            iflag      <= 1'b0;
            tflag      <= 1'b0;
            err_q      <= 1'b0;
            vtok_q     <= 1'b0;
        end else begin
            vtok_q  <= bus.en & vflag & tflag & ~err_q;
            start_q <= (state == ST_SETTLE) && (state_nxt == ST_CONVERT);

            if (load_sel) begin
                sel_q      <= pick_ch;
                settle_cnt <= 8'd0;
            end else if (state == ST_SETTLE) begin
                settle_cnt <= settle_cnt + 8'd1;
            end

            if (state != ST_CONVERT)    wait_cnt <= 6'd0;
            else if (wait_cnt != 6'h3F) wait_cnt <= wait_cnt + 6'd1;

            if (eoc_ok) data_q <= bus.adc_data;

            if (!bus.en || timeout) begin
                vflag <= 1'b0;
                iflag <= 1'b0;
                tflag <= 1'b0;
            end
            if (!bus.en)     err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;

            if (store) begin
                last_ch <= sel_q;
                case (sel_q)
                    CH_V: begin vbat_q <= data_q; vflag <= 1'b1; end
                    CH_I: begin ibat_q <= data_q; iflag <= 1'b1; end
                    CH_T: begin tbat_q <= data_q; tflag <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    assign bus.adc_sel   = sel_q;
    assign bus.adc_start = start_q;
    assign bus.vbat      = vbat_q;
    assign bus.ibat      = ibat_q;
    assign bus.tbat      = tbat_q;
    assign bus.vtok      = vtok_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_batcharger_adcseq.sv
// Directed bench for batcharger_adcseq with a small behavioural ADC model.
module tb_batcharger_adcseq;
    import batcharger_pkg::*;

    logic clk;
    logic rstz;
    int   n_checks = 0;
    int   n_pass   = 0;

    batcharger_adcseq_if bus ();
    wire dvdd;
    wire dgnd;
    assign dvdd = 1'b1;
    assign dgnd = 1'b0;

    batcharger_adcseq #(.SETTLE(3), .TIMEOUT(63)) dut (
        .clk  (clk),
        .rstz (rstz),
        .bus  (bus),
        .dvdd (dvdd),
        .dgnd (dgnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: eoc 'lat' cycles after the start cycle, data by channel.
    logic       model_on = 1'b1;
    int         lat      = 5;
    int         since    = -1;
    logic [1:0] sel_seen = 2'b00;
    logic [7:0] v_val    = 8'hA0;
    logic [7:0] i_val    = 8'h55;
    logic [7:0] t_val    = 8'h40;
    logic       m_eoc    = 1'b0;
    logic [7:0] m_data   = 8'h00;
    logic       man_eoc  = 1'b0;
    logic [7:0] man_data = 8'h00;

    always @(negedge clk) begin
        m_eoc = 1'b0;
        if (bus.adc_start === 1'b1) begin
            since    = 0;
            sel_seen = bus.adc_sel;
        end else if (since >= 0) begin
            since++;
        end
        if (model_on && since == lat) begin
            m_eoc = 1'b1;
            since = -1;
        end
        case (sel_seen)
            2'b00:   m_data = v_val;
            2'b01:   m_data = i_val;
            default: m_data = t_val;
        endcase
    end

    assign bus.adc_eoc  = m_eoc | man_eoc;
    assign bus.adc_data = man_eoc ? man_data : m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(input int budget, output logic [1:0] sel, output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.adc_start !== 1'b1 && n < budget);
        cycles = n;
        sel    = bus.adc_sel;
        chk("start_seen", 32'(bus.adc_start), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(bus.state_dbg), 32'(ST_IDLE));
        chk({tag, "_sel"},   32'(bus.adc_sel),   32'd0);
        chk({tag, "_start"}, 32'(bus.adc_start), 32'd0);
        chk({tag, "_vbat"},  32'(bus.vbat),      32'h00);
        chk({tag, "_ibat"},  32'(bus.ibat),      32'h00);
        chk({tag, "_tbat"},  32'(bus.tbat),      32'h00);
        chk({tag, "_vtok"},  32'(bus.vtok),      32'd0);
        chk({tag, "_err"},   32'(bus.err),       32'd0);
    endtask

    logic [1:0] sel;
    int         cyc;

    initial begin
        rstz       = 1'b0;
        bus.en     = 1'b0;
        bus.vmonen = 1'b0;
        bus.imonen = 1'b0;
        bus.tmonen = 1'b0;
        step(3);
        chk_reset_vals("rst");
        rstz = 1'b1;
        step(2);

        // V and T enabled: V first, then T; vtok one cycle after tbat write.
        bus.en     = 1'b1;
        bus.vmonen = 1'b1;
        bus.tmonen = 1'b1;
        step(1);
        chk("s1_settle", 32'(bus.state_dbg), 32'(ST_SETTLE));
        chk("s1_sel_v",  32'(bus.adc_sel),   32'd0);
        step(2);
        chk("s1_nostart_c3", 32'(bus.adc_start), 32'd0);
        step(1);
        chk("s1_start_c4", 32'(bus.adc_start), 32'd1);
        chk("s1_conv_c4",  32'(bus.state_dbg), 32'(ST_CONVERT));
        step(1);
        chk("s1_start_1cyc", 32'(bus.adc_start), 32'd0);
        step(5);
        chk("s1_store_c10", 32'(bus.state_dbg), 32'(ST_STORE));
        chk("s1_vbat_pre",  32'(bus.vbat),      32'h00);
        step(1);
        chk("s1_vbat_c11", 32'(bus.vbat),      32'hA0);
        chk("s1_idle_c11", 32'(bus.state_dbg), 32'(ST_IDLE));
        step(1);
        chk("s1_sel_t", 32'(bus.adc_sel), 32'd2);
        step(10);
        chk("s1_tbat",     32'(bus.tbat), 32'h40);
        chk("s1_vtok_pre", 32'(bus.vtok), 32'd0);
        step(1);
        chk("s1_vtok_rise", 32'(bus.vtok), 32'd1);

        // All three enabled: 00, 01, 10, 00.
        bus.imonen = 1'b1;
        v_val      = 8'hA1;
        wait_start(40, sel, cyc);
        chk("s2_sel0", 32'(sel), 32'd0);
        wait_start(40, sel, cyc);
        chk("s2_sel1", 32'(sel), 32'd1);
        chk("s2_vtok1", 32'(bus.vtok), 32'd1);
        wait_start(40, sel, cyc);
        chk("s2_sel2", 32'(sel), 32'd2);
        chk("s2_ibat", 32'(bus.ibat), 32'h55);
        wait_start(40, sel, cyc);
        chk("s2_sel3", 32'(sel), 32'd0);
        chk("s2_vbat", 32'(bus.vbat), 32'hA1);
        chk("s2_vtok", 32'(bus.vtok), 32'd1);

        // I only; the V conversion under way must still complete.
        bus.vmonen = 1'b0;
        bus.tmonen = 1'b0;
        v_val      = 8'hA2;
        i_val      = 8'h66;
        wait_start(40, sel, cyc);
        chk("s5_sel_i_a", 32'(sel), 32'd1);
        chk("s5_gap_a",   32'(cyc), 32'd11);
        chk("s5_vbat_kept_conv", 32'(bus.vbat), 32'hA2);
        wait_start(40, sel, cyc);
        chk("s5_sel_i_b", 32'(sel), 32'd1);
        chk("s5_gap_b",   32'(cyc), 32'd11);
        chk("s5_ibat",    32'(bus.ibat), 32'h66);
        chk("s5_tbat",    32'(bus.tbat), 32'h40);
        chk("s5_vtok",    32'(bus.vtok), 32'd1);

        // No enables: idle with everything held.
        bus.imonen = 1'b0;
        step(30);
        chk("s6_idle",  32'(bus.state_dbg), 32'(ST_IDLE));
        chk("s6_vbat",  32'(bus.vbat),      32'hA2);
        chk("s6_ibat",  32'(bus.ibat),      32'h66);
        chk("s6_vtok",  32'(bus.vtok),      32'd1);
        chk("s6_start", 32'(bus.adc_start), 32'd0);

        // Timeout: no eoc at all.
        model_on   = 1'b0;
        bus.imonen = 1'b1;
        wait_start(40, sel, cyc);
        step(63);
        chk("s3_err_pre",  32'(bus.err),       32'd0);
        chk("s3_conv_pre", 32'(bus.state_dbg), 32'(ST_CONVERT));
        step(1);
        bus.imonen = 1'b0;
        chk("s3_err",  32'(bus.err),       32'd1);
        chk("s3_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("s3_ibat", 32'(bus.ibat),      32'h66);
        step(1);
        chk("s3_vtok", 32'(bus.vtok), 32'd0);
        bus.en = 1'b0;
        step(1);
        chk("s3_err_clr", 32'(bus.err), 32'd0);
        bus.en = 1'b1;
        step(2);
        chk("s3_err_stay0", 32'(bus.err),  32'd0);
        chk("s3_ibat_held", 32'(bus.ibat), 32'h66);

        // en dropped in CONVERT, then a late eoc.
        bus.vmonen = 1'b1;
        wait_start(40, sel, cyc);
        step(2);
        bus.en     = 1'b0;
        bus.vmonen = 1'b0;
        step(1);
        chk("s4_idle", 32'(bus.state_dbg), 32'(ST_IDLE));
        man_data = 8'hFF;
        man_eoc  = 1'b1;
        step(1);
        man_eoc = 1'b0;
        step(1);
        chk("s4_vbat",  32'(bus.vbat),      32'hA2);
        chk("s4_ibat",  32'(bus.ibat),      32'h66);
        chk("s4_tbat",  32'(bus.tbat),      32'h40);
        chk("s4_idle2", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("s4_vtok",  32'(bus.vtok),      32'd0);

        // eoc held through SETTLE and the start cycle is ignored; N=1 accepted.
        bus.en     = 1'b1;
        bus.vmonen = 1'b1;
        man_eoc    = 1'b1;
        step(4);
        chk("s7_start", 32'(bus.adc_start), 32'd1);
        man_eoc = 1'b0;
        step(1);
        chk("s7_still_conv", 32'(bus.state_dbg), 32'(ST_CONVERT));
        man_data   = 8'h12;
        man_eoc    = 1'b1;
        bus.vmonen = 1'b0;
        step(1);
        man_eoc = 1'b0;
        chk("s7_store", 32'(bus.state_dbg), 32'(ST_STORE));
        step(1);
        chk("s7_vbat", 32'(bus.vbat), 32'h12);
        chk("s7_vtok", 32'(bus.vtok), 32'd0);

        // Reset pulsed during SETTLE; afterwards V is skipped and I goes first.
        model_on   = 1'b1;
        bus.imonen = 1'b1;
        bus.tmonen = 1'b1;
        step(2);
        chk("s8_settle", 32'(bus.state_dbg), 32'(ST_SETTLE));
        rstz = 1'b0;
        #1;
        chk_reset_vals("s8");
        @(negedge clk);
        rstz = 1'b1;
        wait_start(40, sel, cyc);
        chk("s8_first_i", 32'(sel), 32'd1);
        bus.imonen = 1'b0;
        bus.tmonen = 1'b0;
        step(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
